mdu_issue_ctrl: RTL and testbench

Issue/writeback controller between the execute stage and the M-extension MDU. It accepts RV32M operations from execute over a valid/ready handshake, holds operands and op code stable at the MDU for the whole operation, and resolves divide-by-zero and signed-overflow cases locally without starting the MDU. It captures the MDU's one-cycle result pulse and presents the result to writeback over a valid/ready handshake. Flush is supported by draining an in-flight MDU operation, since the MDU has no abort input.

---
 rtl/mdu_issue_ctrl_if.sv | 35 +++
 rtl/mdu_issue_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mdu_issue_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_issue_ctrl_if.sv
// Execute / MDU / writeback signal bundle for the MDU issue controller.
// slave = the controller, master = the surrounding pipeline and MDU.
interface mdu_issue_ctrl_if;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [2:0]  ex_funct3_i;
  logic [4:0]  ex_rd_i;
  logic [31:0] ex_rs1_i;
  logic [31:0] ex_rs2_i;
  logic        flush_i;
  logic        mdu_valid_o;
  logic [2:0]  mdu_op_o;
  logic [31:0] mdu_rs1_o;
  logic [31:0] mdu_rs2_o;
  logic        mdu_ready_i;
  logic [31:0] mdu_rd_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;

  modport slave (
    input  ex_valid_i, ex_funct3_i, ex_rd_i, ex_rs1_i, ex_rs2_i, flush_i,
    input  mdu_ready_i, mdu_rd_i, wb_ready_i,
    output ex_ready_o, mdu_valid_o, mdu_op_o, mdu_rs1_o, mdu_rs2_o,
    output wb_valid_o, wb_rd_o, wb_data_o
  );

  modport master (
    output ex_valid_i, ex_funct3_i, ex_rd_i, ex_rs1_i, ex_rs2_i, flush_i,
    output mdu_ready_i, mdu_rd_i, wb_ready_i,
    input  ex_ready_o, mdu_valid_o, mdu_op_o, mdu_rs1_o, mdu_rs2_o,
    input  wb_valid_o, wb_rd_o, wb_data_o
  );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// Issue/writeback controller for the RV32M MDU: holds operands for the whole
// operation, resolves div-by-zero/overflow locally, drains on flush.
//
// state | meaning
// IDLE  | ready for a new M-op from execute
// ISSUE | one-cycle start pulse to the MDU
// WAIT  | operands held, waiting for the MDU done pulse (timed)
// WB    | result presented to writeback until accepted
// DRAIN | flushed op still running in the MDU; result discarded (timed)
module mdu_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit FAST_PATH      = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  mdu_issue_ctrl_if.slave  bus,
  output logic             busy_o,
  output logic             err_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);

  logic [2:0]    state_q, state_d;
  logic          started_q;
  logic [2:0]    op_q;
  logic [4:0]    rd_q;
  logic [31:0]   rs1_q, rs2_q;
  logic [31:0]   data_q, data_d;
  logic [TW-1:0] tmr_q, tmr_d;

  logic          accept;
  logic          fast;
  logic [31:0]   fast_data;
  logic          rs2_zero, ovf, tmo, err;

  // started_q keeps ex_ready_o low until the first edge out of reset
  assign accept   = (state_q == S_IDLE) & started_q & bus.ex_valid_i & ~bus.flush_i;
  assign rs2_zero = (bus.ex_rs2_i == 32'h0);
  assign ovf      = (bus.ex_rs1_i == 32'h8000_0000) & (bus.ex_rs2_i == 32'hFFFF_FFFF);
  assign tmo      = (tmr_q == '0);

  always_comb begin
    fast      = 1'b0;
    fast_data = 32'h0;
    if (FAST_PATH) begin
      case (bus.ex_funct3_i)
        3'b100: begin
          if (rs2_zero) begin
            fast      = 1'b1;
            fast_data = 32'hFFFF_FFFF;
          end else if (ovf) begin
            fast      = 1'b1;
            fast_data = 32'h8000_0000;
          end
        end
        3'b101: begin
          if (rs2_zero) begin
            fast      = 1'b1;
            fast_data = 32'hFFFF_FFFF;
          end
        end
        3'b110: begin
          if (rs2_zero) begin
            fast      = 1'b1;
            fast_data = bus.ex_rs1_i;
          end else if (ovf) begin
            fast      = 1'b1;
            fast_data = 32'h0;
          end
        end
        3'b111: begin
          if (rs2_zero) begin
            fast      = 1'b1;
            fast_data = bus.ex_rs1_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    tmr_d   = tmr_q;
    err     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = fast ? S_WB : S_ISSUE;
          if (fast) data_d = fast_data;
        end
      end
      S_ISSUE: begin
        tmr_d   = TMO_LOAD;
        state_d = bus.flush_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        tmr_d = tmr_q - 1'b1;
        err   = tmo & ~bus.mdu_ready_i;
        if (bus.flush_i) begin
          state_d = (bus.mdu_ready_i | tmo) ? S_IDLE : S_DRAIN;
        end else if (bus.mdu_ready_i) begin
          data_d  = bus.mdu_rd_i;
          state_d = S_WB;
        end else if (tmo) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        tmr_d = tmr_q - 1'b1;
        err   = tmo & ~bus.mdu_ready_i;
        if (bus.mdu_ready_i | tmo) state_d = S_IDLE;
      end
      S_WB: begin
        if (bus.wb_ready_i | bus.flush_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      started_q <= 1'b0;
      op_q      <= 3'h0;
      rd_q      <= 5'h0;
      rs1_q     <= 32'h0;
      rs2_q     <= 32'h0;
      data_q    <= 32'h0;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      data_q    <= data_d;
      tmr_q     <= tmr_d;
      if (accept) begin
        op_q  <= bus.ex_funct3_i;
        rd_q  <= bus.ex_rd_i;
        rs1_q <= bus.ex_rs1_i;
        rs2_q <= bus.ex_rs2_i;
      end
    end
  end

  assign bus.ex_ready_o  = (state_q == S_IDLE) & started_q;
  assign bus.mdu_valid_o = (state_q == S_ISSUE);
  assign bus.mdu_op_o    = op_q;
  assign bus.mdu_rs1_o   = rs1_q;
  assign bus.mdu_rs2_o   = rs2_q;
  assign bus.wb_valid_o  = (state_q == S_WB);
  assign bus.wb_rd_o     = rd_q;
  assign bus.wb_data_o   = data_q;
  assign busy_o          = (state_q != S_IDLE);
  assign err_o           = err;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: directed scenarios plus randomized ops checked
// against an arithmetic RV32M reference and a latency-programmable MDU model.
module tb_mdu_issue_ctrl;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, err;
  always #5 clk = ~clk;

  mdu_issue_ctrl_if bus();

  mdu_issue_ctrl #(.TIMEOUT_CYCLES(TMO), .FAST_PATH(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy_o(busy), .err_o(err)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // MDU model state
  int          mdu_lat = 3;
  bit          mdu_mute = 0;
  int          starts = 0;
  bit          op_changed = 0;
  bit          pend = 0;
  int          cnt = 0;
  logic [2:0]  cur_op = 3'h0;
  logic [31:0] cur_a = 32'h0, cur_b = 32'h0;

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit ov;
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (f >= 3'd4 && b == 0) return 1'b1;
    if ((f == 3'd4 || f == 3'd6) && ov) return 1'b1;
    return 1'b0;
  endfunction

  // MDU: sees the start pulse at negedge, answers mdu_lat negedges later
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 0;
      bus.mdu_ready_i = 1'b0;
      bus.mdu_rd_i = 32'h0;
    end else begin
      bus.mdu_ready_i = 1'b0;
      if (pend) begin
        if (bus.mdu_op_o !== cur_op) op_changed = 1;
        if (cnt <= 1) begin
          bus.mdu_ready_i = 1'b1;
          bus.mdu_rd_i = ref_result(cur_op, cur_a, cur_b);
          pend = 0;
        end else cnt--;
      end
      if (bus.mdu_valid_o === 1'b1) begin
        starts++;
        cur_op = bus.mdu_op_o;
        cur_a = bus.mdu_rs1_o;
        cur_b = bus.mdu_rs2_o;
        cnt = mdu_lat;
        pend = !mdu_mute;
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] f, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    tick();
    while (bus.ex_ready_o !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      total_cnt++;
      $display("FAIL send_wait ex_ready_o=%b required 1 within 200 cycles", bus.ex_ready_o);
    end
    bus.ex_valid_i = 1'b1;
    bus.ex_funct3_i = f;
    bus.ex_rd_i = rd;
    bus.ex_rs1_i = a;
    bus.ex_rs2_i = b;
    @(posedge clk);
    #1;
    bus.ex_valid_i = 1'b0;
  endtask

  task automatic wait_wb(output bit got, output int cyc, output logic [4:0] rd, output logic [31:0] d);
    got = 0; cyc = 0; rd = 5'h0; d = 32'h0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.wb_valid_o === 1'b1) begin
        got = 1; cyc = i; rd = bus.wb_rd_o; d = bus.wb_data_o;
        break;
      end
    end
  endtask

  task automatic take_wb;
    bus.wb_ready_i = 1'b1;
    tick();
    bus.wb_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    total_cnt++;
    if ({bus.ex_ready_o, busy, bus.mdu_valid_o, bus.mdu_op_o, bus.mdu_rs1_o, bus.mdu_rs2_o,
         bus.wb_valid_o, bus.wb_rd_o, bus.wb_data_o, err} !== '0)
      $display("FAIL reset_outputs some output nonzero, ex_ready=%b busy=%b wb_data=%h required all 0",
               bus.ex_ready_o, busy, bus.wb_data_o);
    else pass_cnt++;
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    total_cnt++;
    if (bus.ex_ready_o !== 1'b0) $display("FAIL reset_ready_before_edge got=%b required 0", bus.ex_ready_o);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (bus.ex_ready_o !== 1'b1) $display("FAIL reset_ready_after_edge got=%b required 1", bus.ex_ready_o);
    else pass_cnt++;
  endtask

  task automatic test_mul;
    bit got; int cyc; logic [4:0] rd; logic [31:0] d; int s0;
    mdu_lat = 4; op_changed = 0; s0 = starts;
    send(3'd0, 5'd5, 32'd7, 32'hFFFF_FFFA);
    wait_wb(got, cyc, rd, d);
    total_cnt++;
    if (!got || d !== 32'hFFFF_FFD6) $display("FAIL mul_data got=%h valid=%b required FFFFFFD6", d, got);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 5'd5) $display("FAIL mul_rd got=%0d required 5", rd); else pass_cnt++;
    total_cnt++;
    if (starts - s0 != 1 || cur_op !== 3'd0)
      $display("FAIL mul_issue pulses=%0d op=%0d required 1 pulse op 0", starts - s0, cur_op);
    else pass_cnt++;
    total_cnt++;
    if (op_changed !== 1'b0) $display("FAIL mul_op_held changed=%b required 0", op_changed); else pass_cnt++;
    take_wb();
  endtask

  task automatic test_fast_path;
    bit got; int cyc; logic [4:0] rd; logic [31:0] d; int s0;
    s0 = starts;
    send(3'd5, 5'd1, 32'd100, 32'd0);
    wait_wb(got, cyc, rd, d);
    total_cnt++;
    if (!got || cyc != 0 || d !== 32'hFFFF_FFFF)
      $display("FAIL fast_divu data=%h delay=%0d required FFFFFFFF at delay 0", d, cyc);
    else pass_cnt++;
    take_wb();
    send(3'd6, 5'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_wb(got, cyc, rd, d);
    total_cnt++;
    if (!got || cyc != 0 || d !== 32'h0 || rd !== 5'd2)
      $display("FAIL fast_rem_ovf data=%h rd=%0d delay=%0d required 0 rd 2 delay 0", d, rd, cyc);
    else pass_cnt++;
    take_wb();
    total_cnt++;
    if (starts != s0) $display("FAIL fast_no_issue pulses=%0d required 0", starts - s0); else pass_cnt++;
  endtask

  task automatic test_wb_stall;
    bit got; int cyc; logic [4:0] rd; logic [31:0] d; bit stable;
    mdu_lat = 3;
    send(3'd4, 5'd7, 32'hFFFF_FFEC, 32'd3);
    wait_wb(got, cyc, rd, d);
    total_cnt++;
    if (!got || d !== 32'hFFFF_FFFA) $display("FAIL stall_data got=%h required FFFFFFFA", d); else pass_cnt++;
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.wb_valid_o !== 1'b1 || bus.wb_data_o !== d || bus.wb_rd_o !== 5'd7 || bus.ex_ready_o !== 1'b0)
        stable = 0;
    end
    total_cnt++;
    if (!stable) $display("FAIL stall_hold stable=%b required 1", stable); else pass_cnt++;
    take_wb();
    total_cnt++;
    if (bus.ex_ready_o !== 1'b1 || bus.wb_valid_o !== 1'b0)
      $display("FAIL stall_release ex_ready=%b wb_valid=%b required 1 0", bus.ex_ready_o, bus.wb_valid_o);
    else pass_cnt++;
  endtask

  task automatic test_flush_drain;
    bit got; int cyc; logic [4:0] rd; logic [31:0] d;
    int ridx, eidx; bit wbseen;
    mdu_lat = 10; ridx = -1; eidx = -1; wbseen = 0;
    send(3'd4, 5'd3, 32'd100, 32'd7);
    tick(); tick(); tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    for (int i = 0; i < 100 && eidx < 0; i++) begin
      tick();
      if (bus.wb_valid_o === 1'b1) wbseen = 1;
      if (bus.mdu_ready_i === 1'b1 && ridx < 0) ridx = i;
      if (bus.ex_ready_o === 1'b1) eidx = i;
    end
    total_cnt++;
    if (wbseen) $display("FAIL drain_no_wb wb_valid seen=%b required 0", wbseen); else pass_cnt++;
    total_cnt++;
    if (ridx < 0 || eidx != ridx + 1)
      $display("FAIL drain_ready_timing ready_idx=%0d ex_ready_idx=%0d required ex_ready one after ready", ridx, eidx);
    else pass_cnt++;
    mdu_lat = 3;
    send(3'd3, 5'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_wb(got, cyc, rd, d);
    total_cnt++;
    if (!got || d !== 32'hFFFF_FFFE || rd !== 5'd4)
      $display("FAIL drain_next_mulhu data=%h rd=%0d required FFFFFFFE rd 4", d, rd);
    else pass_cnt++;
    take_wb();
  endtask

  task automatic test_timeout;
    int vidx, eidx, errs; bit wbseen, rdy_after;
    mdu_mute = 1; vidx = -1; eidx = -1; errs = 0; wbseen = 0; rdy_after = 0;
    send(3'd0, 5'd6, 32'd3, 32'd4);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.mdu_valid_o === 1'b1 && vidx < 0) vidx = i;
      if (bus.wb_valid_o === 1'b1) wbseen = 1;
      if (err === 1'b1) begin
        errs++;
        if (eidx < 0) eidx = i;
      end
      if (eidx >= 0 && i == eidx + 1) begin
        rdy_after = (bus.ex_ready_o === 1'b1) && (busy === 1'b0);
        break;
      end
    end
    mdu_mute = 0;
    total_cnt++;
    if (vidx < 0 || eidx != vidx + 1 + TMO)
      $display("FAIL timeout_err_timing err_idx=%0d issue_idx=%0d required err %0d cycles after WAIT entry", eidx, vidx, TMO);
    else pass_cnt++;
    total_cnt++;
    if (errs != 1) $display("FAIL timeout_err_pulse count=%0d required 1", errs); else pass_cnt++;
    total_cnt++;
    if (wbseen || !rdy_after)
      $display("FAIL timeout_idle wb_seen=%b idle_ready=%b required 0 1", wbseen, rdy_after);
    else pass_cnt++;
  endtask

  task automatic test_async_reset;
    bit got; int cyc; logic [4:0] rd; logic [31:0] d;
    mdu_lat = 20;
    send(3'd1, 5'd8, 32'd5, 32'd6);
    tick(); tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.ex_ready_o, busy, bus.mdu_valid_o, bus.mdu_op_o, bus.mdu_rs1_o, bus.mdu_rs2_o,
         bus.wb_valid_o, bus.wb_rd_o, bus.wb_data_o, err} !== '0)
      $display("FAIL async_reset_outputs busy=%b op=%0d rs1=%h required all 0", busy, bus.mdu_op_o, bus.mdu_rs1_o);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    mdu_lat = 2;
    send(3'd7, 5'd9, 32'd17, 32'd5);
    wait_wb(got, cyc, rd, d);
    total_cnt++;
    if (!got || d !== 32'd2 || rd !== 5'd9)
      $display("FAIL async_reset_remu data=%h rd=%0d required 2 rd 9", d, rd);
    else pass_cnt++;
    take_wb();
  endtask

  task automatic test_flush_wb_idle;
    bit got; int cyc; logic [4:0] rd; logic [31:0] d; int s0;
    send(3'd5, 5'd10, 32'd1, 32'd0);
    wait_wb(got, cyc, rd, d);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    total_cnt++;
    if (!got || bus.wb_valid_o !== 1'b0 || bus.ex_ready_o !== 1'b1)
      $display("FAIL flush_wb wb_valid=%b ex_ready=%b required 0 1", bus.wb_valid_o, bus.ex_ready_o);
    else pass_cnt++;
    s0 = starts;
    bus.flush_i = 1'b1;
    bus.ex_valid_i = 1'b1;
    bus.ex_funct3_i = 3'd0;
    @(posedge clk);
    #1;
    bus.ex_valid_i = 1'b0;
    bus.flush_i = 1'b0;
    tick(); tick();
    total_cnt++;
    if (busy !== 1'b0 || starts != s0)
      $display("FAIL flush_idle busy=%b pulses=%0d required 0 0", busy, starts - s0);
    else pass_cnt++;
  endtask

  task automatic test_random;
    bit got; int cyc; logic [4:0] rd, exp_rd; logic [31:0] d, a, b, exp_d;
    logic [2:0] f; int s0, r; bit fst;
    op_changed = 0;
    for (int n = 0; n < 40; n++) begin
      f = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 5);
      a = $urandom;
      b = $urandom;
      if (r == 0) b = 32'h0;
      if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      exp_rd = 5'($urandom_range(0, 31));
      exp_d = ref_result(f, a, b);
      fst = is_fast(f, a, b);
      mdu_lat = $urandom_range(1, 6);
      s0 = starts;
      send(f, exp_rd, a, b);
      wait_wb(got, cyc, rd, d);
      total_cnt++;
      if (!got || d !== exp_d || rd !== exp_rd)
        $display("FAIL rand_result op=%0d a=%h b=%h data=%h rd=%0d required %h rd %0d", f, a, b, d, rd, exp_d, exp_rd);
      else pass_cnt++;
      total_cnt++;
      if (starts - s0 != (fst ? 0 : 1) || (fst && cyc != 0))
        $display("FAIL rand_path op=%0d pulses=%0d delay=%0d required pulses %0d", f, starts - s0, cyc, fst ? 0 : 1);
      else pass_cnt++;
      r = $urandom_range(0, 3);
      for (int k = 0; k < r; k++) tick();
      take_wb();
    end
    total_cnt++;
    if (op_changed !== 1'b0) $display("FAIL rand_op_held changed=%b required 0", op_changed); else pass_cnt++;
  endtask

  initial begin
    bus.ex_valid_i = 1'b0;
    bus.ex_funct3_i = 3'h0;
    bus.ex_rd_i = 5'h0;
    bus.ex_rs1_i = 32'h0;
    bus.ex_rs2_i = 32'h0;
    bus.flush_i = 1'b0;
    bus.wb_ready_i = 1'b0;
    test_reset();
    test_mul();
    test_fast_path();
    test_wb_stall();
    test_flush_drain();
    test_timeout();
    test_async_reset();
    test_flush_wb_idle();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
